// File: rtl/regbank_pkg.sv
// Shared constants and FSM encoding for the parametrised integer register bank.
package regbank_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef enum logic {
    RUN   = 1'b0,
    SCRUB = 1'b1
  } state_t;

  // ABI register indices
  localparam int ZERO = 0;
  localparam int RA   = 1;
  localparam int SP   = 2;

endpackage

// File: rtl/reg_bank_param_if.sv
// Decode/writeback-facing bus of the register bank: one write port, two read ports, busy flag.
interface reg_bank_param_if
  import regbank_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS
) ();

  localparam int AW = $clog2(NREGS);

  logic            wr_en_i;
  logic [AW-1:0]   RD_ADDR_i;
  logic [XLEN-1:0] data_i;
  logic [AW-1:0]   RS1_ADDR_i;
  logic [AW-1:0]   RS2_ADDR_i;
  logic [XLEN-1:0] RS1_data_o;
  logic [XLEN-1:0] RS2_data_o;
  logic            init_busy_o;

  modport master (
    output wr_en_i,
    output RD_ADDR_i,
    output data_i,
    output RS1_ADDR_i,
    output RS2_ADDR_i,
    input  RS1_data_o,
    input  RS2_data_o,
    input  init_busy_o
  );

  modport slave (
    input  wr_en_i,
    input  RD_ADDR_i,
    input  data_i,
    input  RS1_ADDR_i,
    input  RS2_ADDR_i,
    output RS1_data_o,
    output RS2_data_o,
    output init_busy_o
  );

endinterface

// File: rtl/regbank_read_port.sv
// Combinational read mux for one source operand: scrub gate, hard-wired zero, write bypass, array.
module regbank_read_port
  import regbank_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            busy,
  input  logic [AW-1:0]   addr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [XLEN-1:0] mem [NREGS],
  output logic [XLEN-1:0] data
);

  logic is_zero;
  logic is_byp;

  assign is_zero = (ZERO_REG != 0) && (addr == '0);
  assign is_byp  = (BYPASS != 0) && wr_en && (addr == wr_addr);

  // Scrub gate outranks everything so a half-cleared bank is never visible.
  always_comb begin
    data = mem[addr];
    if (busy) begin
      data = '0;
    end else if (is_zero) begin
      data = '0;
    end else if (is_byp) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised integer register bank with post-reset scrub engine and two combinational read ports.
module reg_bank_param
  import regbank_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           rst,
  reg_bank_param_if.slave bus
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_nxt;
  logic            scrub_we;
  logic            busy;
  logic            wr_ok;
  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCRUB;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    scrub_we  = 1'b0;
    if (state == SCRUB) begin
      scrub_we = 1'b1;
      cnt_nxt  = cnt + 1'b1;
      if (cnt == LAST) begin
        state_nxt = RUN;
      end
    end
  end

  assign busy  = (state == SCRUB);
  assign wr_ok = bus.wr_en_i && !((ZERO_REG != 0) && (bus.RD_ADDR_i == '0));

  // Scrub owns the array while busy; pipeline writes in that window are simply lost.
  always_ff @(posedge clk) begin
    if (scrub_we) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[bus.RD_ADDR_i] <= bus.data_i;
    end
  end

  regbank_read_port #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rs1 (
    .busy    (busy),
    .addr    (bus.RS1_ADDR_i),
    .wr_en   (bus.wr_en_i),
    .wr_addr (bus.RD_ADDR_i),
    .wr_data (bus.data_i),
    .mem     (mem),
    .data    (bus.RS1_data_o)
  );

  regbank_read_port #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rs2 (
    .busy    (busy),
    .addr    (bus.RS2_ADDR_i),
    .wr_en   (bus.wr_en_i),
    .wr_addr (bus.RD_ADDR_i),
    .wr_data (bus.data_i),
    .mem     (mem),
    .data    (bus.RS2_data_o)
  );

  assign bus.init_busy_o = busy;

endmodule
